// File: rtl/wall_pkg.sv
// Shared types and default geometry for the wall ROM arbiter and its helpers.
package wall_pkg;

  localparam int ROM_ROWS = 480;
  localparam int ROM_COLS = 640;
  localparam int BOX_MAX  = 32;

  typedef logic [9:0] coord_t;
  typedef logic [5:0] size_t;

  typedef enum logic [2:0] {
    IDLE,
    VFETCH,
    VCAP,
    CSCAN,
    CDRAIN,
    CRESP
  } state_t;

  // A zero-sized box still covers its corner pixel; oversize boxes saturate.
  function automatic size_t clamp_size(input size_t s, input int max_size);
    if (s == '0) return size_t'(1);
    if (int'(s) > max_size) return size_t'(max_size);
    return s;
  endfunction

endpackage

// File: rtl/wall_rom_arbiter_if.sv
// Bus bundle between the wall ROM arbiter (slave), its video/collision
// clients and the synchronous wall ROM (master side).
interface wall_rom_arbiter_if #(
  parameter int COLS = wall_pkg::ROM_COLS
);
  import wall_pkg::*;

  logic            line_req;
  coord_t          line_y;
  logic [COLS-1:0] line_data;
  logic            line_valid;

  logic            col_req;
  coord_t          col_x;
  coord_t          col_y;
  size_t           col_w;
  size_t           col_h;
  logic            col_ack;
  logic            col_hit;
  logic            busy;

  coord_t          rom_addr;
  logic [COLS-1:0] rom_data;

  modport master (
    output line_req, line_y, col_req, col_x, col_y, col_w, col_h, rom_data,
    input  line_data, line_valid, col_ack, col_hit, busy, rom_addr
  );

  modport slave (
    input  line_req, line_y, col_req, col_x, col_y, col_w, col_h, rom_data,
    output line_data, line_valid, col_ack, col_hit, busy, rom_addr
  );

endinterface

// File: rtl/wall_span_check.sv
// Combinational row hit for one box row: OR of rom_data[x +: w].
// WALL_OOB_SOLID_EN makes out-of-bounds pixels count as wall.
module wall_span_check #(
  parameter int ROM_COLS = wall_pkg::ROM_COLS,
  parameter int BOX_MAX  = wall_pkg::BOX_MAX
) (
  input  logic [ROM_COLS-1:0] rom_data,
  input  wall_pkg::coord_t    x,
  input  wall_pkg::size_t     w,
  input  logic                row_oob,
  output logic                hit
);
  import wall_pkg::*;

  localparam int IW = $clog2(ROM_COLS);

`ifdef WALL_OOB_SOLID_EN
  localparam logic OOB_HIT = 1'b1;
`else
  localparam logic OOB_HIT = 1'b0;
`endif

  logic [BOX_MAX-1:0] pix_hit;

  for (genvar gi = 0; gi < BOX_MAX; gi++) begin : g_pix
    logic [10:0]   px;
    logic [IW-1:0] idx;
    logic          col_oob;

    assign px          = {1'b0, x} + 11'(gi);
    assign col_oob     = (int'(px) >= ROM_COLS);
    assign idx         = col_oob ? '0 : px[IW-1:0];
    assign pix_hit[gi] = (gi < int'(w)) && (col_oob ? OOB_HIT : rom_data[idx]);
  end

  // A row below the ROM has no valid data; only the build option decides it.
  assign hit = row_oob ? OOB_HIT : |pix_hit;

endmodule

// File: rtl/wall_rom_arbiter.sv
// Shares one synchronous wall ROM between the video row fetcher (priority)
// and the background collision box scanner. Option macro: WALL_OOB_SOLID_EN.
module wall_rom_arbiter #(
  parameter int ROM_ROWS = wall_pkg::ROM_ROWS,
  parameter int ROM_COLS = wall_pkg::ROM_COLS,
  parameter int BOX_MAX  = wall_pkg::BOX_MAX
) (
  input logic               Clk,
  input logic               Reset_n,
  wall_rom_arbiter_if.slave bus
);
  import wall_pkg::*;

  state_t              state_reg;
  state_t              resume_reg;
  coord_t              box_x_reg;
  coord_t              box_y_reg;
  size_t               box_w_reg;
  size_t               box_h_reg;
  size_t               row_cnt_reg;
  logic                issue_v_reg;
  logic                issue_oob_reg;
  logic                eval_v_reg;
  logic                eval_oob_reg;
  logic                hit_acc_reg;
  logic                vid_oob_reg;
  coord_t              rom_addr_reg;
  logic [ROM_COLS-1:0] line_data_reg;
  logic                line_valid_reg;
  logic                col_ack_reg;
  logic                col_hit_reg;
  logic                busy_reg;

  logic        row_hit;
  logic [10:0] next_row;
  logic        next_oob;
  logic        line_oob;
  logic        col_y_oob;

  assign next_row  = {1'b0, box_y_reg} + {5'b0, row_cnt_reg};
  assign next_oob  = (int'(next_row) >= ROM_ROWS);
  assign line_oob  = (int'(bus.line_y) >= ROM_ROWS);
  assign col_y_oob = (int'(bus.col_y) >= ROM_ROWS);

  wall_span_check #(
    .ROM_COLS (ROM_COLS),
    .BOX_MAX  (BOX_MAX)
  ) u_span (
    .rom_data (bus.rom_data),
    .x        (box_x_reg),
    .w        (box_w_reg),
    .row_oob  (eval_oob_reg),
    .hit      (row_hit)
  );

  // issue_* tracks what rom_addr holds this cycle; eval_* what rom_data holds.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      resume_reg     <= IDLE;
      box_x_reg      <= '0;
      box_y_reg      <= '0;
      box_w_reg      <= '0;
      box_h_reg      <= '0;
      row_cnt_reg    <= '0;
      issue_v_reg    <= 1'b0;
      issue_oob_reg  <= 1'b0;
      eval_v_reg     <= 1'b0;
      eval_oob_reg   <= 1'b0;
      hit_acc_reg    <= 1'b0;
      vid_oob_reg    <= 1'b0;
      rom_addr_reg   <= '0;
      line_data_reg  <= '0;
      line_valid_reg <= 1'b0;
      col_ack_reg    <= 1'b0;
      col_hit_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      line_valid_reg <= 1'b0;
      col_ack_reg    <= 1'b0;
      eval_v_reg     <= issue_v_reg;
      eval_oob_reg   <= issue_oob_reg;
      if (eval_v_reg) hit_acc_reg <= hit_acc_reg | row_hit;

      case (state_reg)
        VFETCH: state_reg <= VCAP;
        VCAP: begin
          line_data_reg  <= vid_oob_reg ? '0 : bus.rom_data;
          line_valid_reg <= 1'b1;
          state_reg      <= resume_reg;
          busy_reg       <= (resume_reg != IDLE);
        end
        default: begin
          if (bus.line_req) begin
            // Video steals the ROM; a running scan picks up where it stopped.
            state_reg     <= VFETCH;
            resume_reg    <= (state_reg == CSCAN || state_reg == CDRAIN) ? state_reg : IDLE;
            busy_reg      <= 1'b1;
            vid_oob_reg   <= line_oob;
            issue_v_reg   <= 1'b0;
            issue_oob_reg <= 1'b0;
            if (!line_oob) rom_addr_reg <= bus.line_y;
          end else begin
            case (state_reg)
              IDLE: begin
                if (bus.col_req) begin
                  box_x_reg     <= bus.col_x;
                  box_y_reg     <= bus.col_y;
                  box_w_reg     <= clamp_size(bus.col_w, BOX_MAX);
                  box_h_reg     <= clamp_size(bus.col_h, BOX_MAX);
                  row_cnt_reg   <= size_t'(1);
                  hit_acc_reg   <= 1'b0;
                  issue_v_reg   <= 1'b1;
                  issue_oob_reg <= col_y_oob;
                  if (!col_y_oob) rom_addr_reg <= bus.col_y;
                  state_reg     <= CSCAN;
                  busy_reg      <= 1'b1;
                end
              end
              CSCAN: begin
                if (row_cnt_reg < box_h_reg) begin
                  issue_v_reg   <= 1'b1;
                  issue_oob_reg <= next_oob;
                  if (!next_oob) rom_addr_reg <= next_row[9:0];
                  row_cnt_reg   <= row_cnt_reg + size_t'(1);
                end else begin
                  issue_v_reg   <= 1'b0;
                  issue_oob_reg <= 1'b0;
                  state_reg     <= CDRAIN;
                end
              end
              CDRAIN: begin
                col_hit_reg <= hit_acc_reg | (eval_v_reg & row_hit);
                col_ack_reg <= 1'b1;
                state_reg   <= CRESP;
              end
              default: begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr_reg;
  assign bus.line_data  = line_data_reg;
  assign bus.line_valid = line_valid_reg;
  assign bus.col_ack    = col_ack_reg;
  assign bus.col_hit    = col_hit_reg;
  assign bus.busy       = busy_reg;

endmodule
